// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, sizes and row-priority helper for the keypad encoder
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN         = 2'd0,
      DEBOUNCE     = 2'd1,
      REPORT       = 2'd2,
      WAIT_RELEASE = 2'd3
   } state_t;

   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 4;
   localparam int CODE_W   = 4;
   localparam logic [NUM_ROWS-1:0] RELEASED = 4'b1111;

   // Lowest-index active-low row wins when several rows are pressed.
   function automatic logic [1:0] low_row_idx(input logic [NUM_ROWS-1:0] rows);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = NUM_ROWS - 1; i >= 0; i--) begin
         if (!rows[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with parameterized width and reset value
module sync_2ff #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/keypad_encoder.sv
// rtl/keypad_encoder.sv - 4x4 keypad scanner, debouncer and key-code encoder with valid/ready output
module keypad_encoder
   import keypad_pkg::*;
#(
   parameter int SCAN_CYCLES     = 4,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                clk,
   input  logic                rst,
   output logic [NUM_COLS-1:0] col_drive,
   input  logic [NUM_ROWS-1:0] row_sense,
   output logic [CODE_W-1:0]   key_code,
   output logic                key_valid,
   input  logic                key_ready
);

   localparam int DWELL_W = $clog2(SCAN_CYCLES + 1);
   localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int COL_W   = $clog2(NUM_COLS);
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_CYCLES - 1);
   localparam logic [DEB_W-1:0]   DEB_DONE   = DEB_W'(DEBOUNCE_CYCLES);
   localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);

   state_t              r_state,   w_state_nxt;
   logic [COL_W-1:0]    r_col,     w_col_nxt;
   logic [DWELL_W-1:0]  r_dwell,   w_dwell_nxt;
   logic [DEB_W-1:0]    r_deb,     w_deb_nxt;
   logic [NUM_ROWS-1:0] r_pattern, w_pattern_nxt;
   logic [CODE_W-1:0]   r_key_code, w_code_nxt;
   logic                r_key_valid, w_valid_nxt;
   logic [NUM_ROWS-1:0] w_rows_s;

   sync_2ff #(
      .WIDTH     (NUM_ROWS),
      .RESET_VAL (RELEASED)
   ) u_row_sync (
      .i_clk (clk),
      .i_rst (rst),
      .i_d   (row_sense),
      .o_q   (w_rows_s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= SCAN;
         r_col       <= '0;
         r_dwell     <= '0;
         r_deb       <= '0;
         r_pattern   <= RELEASED;
         r_key_code  <= '0;
         r_key_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_col       <= w_col_nxt;
         r_dwell     <= w_dwell_nxt;
         r_deb       <= w_deb_nxt;
         r_pattern   <= w_pattern_nxt;
         r_key_code  <= w_code_nxt;
         r_key_valid <= w_valid_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_col_nxt     = r_col;
      w_dwell_nxt   = r_dwell;
      w_deb_nxt     = r_deb;
      w_pattern_nxt = r_pattern;
      w_code_nxt    = r_key_code;
      w_valid_nxt   = r_key_valid;
      case (r_state)
         SCAN: begin
            if (r_dwell == DWELL_LAST) begin
               w_dwell_nxt = '0;
               if (w_rows_s != RELEASED) begin
                  w_pattern_nxt = w_rows_s;
                  w_deb_nxt     = '0;
                  w_state_nxt   = DEBOUNCE;
               end else begin
                  w_col_nxt = r_col + 1'b1;
               end
            end else begin
               w_dwell_nxt = r_dwell + 1'b1;
            end
         end
         DEBOUNCE: begin
            if (r_deb == DEB_DONE) begin
               w_state_nxt = REPORT;
               w_valid_nxt = 1'b1;
               w_code_nxt  = {low_row_idx(r_pattern), r_col};
            end else if (w_rows_s == RELEASED) begin
               w_state_nxt = SCAN;
               w_col_nxt   = r_col + 1'b1;
               w_dwell_nxt = '0;
            end else if (w_rows_s != r_pattern) begin
               w_pattern_nxt = w_rows_s;
               w_deb_nxt     = '0;
            end else begin
               w_deb_nxt = r_deb + 1'b1;
            end
         end
         REPORT: begin
            if (key_ready) begin
               w_valid_nxt = 1'b0;
               w_deb_nxt   = '0;
               w_state_nxt = WAIT_RELEASE;
            end
         end
         WAIT_RELEASE: begin
            // Any press while waiting restarts the release qualification.
            if (w_rows_s != RELEASED) begin
               w_deb_nxt = '0;
            end else if (r_deb == DEB_LAST) begin
               w_deb_nxt   = '0;
               w_dwell_nxt = '0;
               w_col_nxt   = r_col + 1'b1;
               w_state_nxt = SCAN;
            end else begin
               w_deb_nxt = r_deb + 1'b1;
            end
         end
         default: w_state_nxt = SCAN;
      endcase
   end

   assign col_drive = ~(NUM_COLS'(1) << r_col);
   assign key_code  = r_key_code;
   assign key_valid = r_key_valid;

endmodule
